// File: rtl/rs232_pkg.sv
// Shared types and elaboration helpers for the RS232 transmit/receive blocks.
package rs232_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int unsigned MIN_BIT_CYCLES = 2;
   localparam int unsigned MIN_STOP_BITS  = 1;
   localparam int unsigned MAX_STOP_BITS  = 2;

   function automatic int unsigned bit_cycles(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and flags the last cycle of each bit.
module rs232_baud_tick #(
   parameter int unsigned BIT_CYCLES = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   logic [CNT_W-1:0] count;

   assign tick = (count == CNT_W'(BIT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || clr || tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/rs232_tx.sv
// UART serializer: byte handshake in, start/data/parity/stop frames out on TD,
// with a one-entry holding register so frames can run back-to-back.
module rs232_tx
   import rs232_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned PARITY_EN   = 0,
   parameter int unsigned PARITY_ODD  = 0,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] TX_Data,
   input  logic       TX_Valid,
   output logic       TX_Ready,
   output logic       TD,
   output logic       Tx_Busy
);

   localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ_HZ, BAUD_RATE);

   if (BIT_CYCLES < MIN_BIT_CYCLES || STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_cfg
      $error("rs232_tx: BIT_CYCLES must be >= 2 and STOP_BITS must be 1 or 2");
   end

   tx_state_t  state;
   logic [7:0] shifter;
   logic [7:0] hold_data;
   logic       hold_valid;
   logic       parity_bit;
   logic [2:0] bit_idx;
   logic       stop_idx;

   logic       tick;
   logic       timer_clr;
   logic       accept;
   logic       frame_end;
   logic       load_direct;
   logic       drain;
   logic       hold_write;
   logic       start_frame;
   logic [7:0] start_byte;
   logic       hold_valid_nxt;
   logic       active_nxt;

   assign timer_clr = (state == IDLE);

   rs232_baud_tick #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_baud_tick (
      .clk  (Clk),
      .rst  (Rst),
      .clr  (timer_clr),
      .tick (tick)
   );

   // A byte accepted on the very last STOP cycle with the holding register empty
   // goes straight into the shifter, keeping the line free of idle bits.
   always_comb begin
      accept         = TX_Valid && TX_Ready;
      frame_end      = (state == STOP) && tick && (stop_idx == 1'(STOP_BITS - 1));
      load_direct    = accept && ((state == IDLE) || frame_end);
      drain          = hold_valid && ((state == IDLE) || frame_end);
      hold_write     = accept && !load_direct;
      start_frame    = load_direct || drain;
      start_byte     = drain ? hold_data : TX_Data;
      hold_valid_nxt = hold_write || (hold_valid && !drain);
      active_nxt     = start_frame || ((state != IDLE) && !frame_end);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         shifter    <= '0;
         hold_data  <= '0;
         hold_valid <= 1'b0;
         parity_bit <= 1'b0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         TD         <= 1'b1;
         TX_Ready   <= 1'b0;
         Tx_Busy    <= 1'b0;
      end else begin
         hold_valid <= hold_valid_nxt;
         TX_Ready   <= !hold_valid_nxt;
         Tx_Busy    <= active_nxt || hold_valid_nxt;

         if (hold_write) begin
            hold_data <= TX_Data;
         end

         case (state)
            START:   TD <= 1'b0;
            DATA:    TD <= shifter[0];
            PARITY:  TD <= parity_bit;
            default: TD <= 1'b1;
         endcase

         if (start_frame) begin
            state      <= START;
            shifter    <= start_byte;
            parity_bit <= (^start_byte) ^ (PARITY_ODD != 0);
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
         end else if (tick) begin
            case (state)
               START: state <= DATA;
               DATA: begin
                  shifter <= {1'b0, shifter[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= (PARITY_EN != 0) ? PARITY : STOP;
                  end
               end
               PARITY: state <= STOP;
               STOP: begin
                  if (frame_end) begin
                     state <= IDLE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: four framing variants, a mid-bit sampling receiver model
// feeding a scoreboard, plus directed timing checks.
module tb_rs232_tx;

   localparam int unsigned CLK_HZ = 1_000_000;
   localparam int unsigned BAUD   = 100_000;
   localparam int unsigned BIT    = CLK_HZ / BAUD;
   localparam int          NUM    = 4;

   logic             Clk = 1'b0;
   logic             Rst = 1'b1;
   logic [7:0]       tx_data [NUM];
   logic [NUM-1:0]   tx_valid;
   logic [NUM-1:0]   ready;
   logic [NUM-1:0]   td;
   logic [NUM-1:0]   busy;

   int unsigned      cyc = 0;
   int               n_pass = 0;
   int               n_total = 0;
   logic [7:0]       exp_q [NUM][$];
   int unsigned      start_q [NUM][$];

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endfunction

   // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
   for (genvar g = 0; g < NUM; g++) begin : g_dut
      localparam int unsigned PEN  = (g == 1 || g == 2) ? 1 : 0;
      localparam int unsigned PODD = (g == 2) ? 1 : 0;
      localparam int unsigned SB   = (g == 3) ? 2 : 1;

      rs232_tx #(
         .CLK_FREQ_HZ (CLK_HZ),
         .BAUD_RATE   (BAUD),
         .PARITY_EN   (PEN),
         .PARITY_ODD  (PODD),
         .STOP_BITS   (SB)
      ) u_dut (
         .Clk      (Clk),
         .Rst      (Rst),
         .TX_Data  (tx_data[g]),
         .TX_Valid (tx_valid[g]),
         .TX_Ready (ready[g]),
         .TD       (td[g]),
         .Tx_Busy  (busy[g])
      );

      task automatic skip(input int unsigned n, inout logic ab);
         for (int unsigned c = 0; c < n; c++) begin
            @(negedge Clk);
            if (Rst) ab = 1'b1;
         end
      endtask

      initial begin : mon
         logic [7:0] got;
         logic [7:0] want;
         logic       st;
         logic       par;
         logic       want_par;
         logic       stop_ok;
         logic       ab;
         forever begin
            @(negedge Clk);
            if (!Rst && td[g] === 1'b0) begin
               start_q[g].push_back(cyc);
               ab = 1'b0;
               skip(BIT / 2 - 1, ab);
               st = td[g];
               for (int unsigned i = 0; i < 8; i++) begin
                  skip(BIT, ab);
                  got[i] = td[g];
               end
               par = 1'b0;
               if (PEN != 0) begin
                  skip(BIT, ab);
                  par = td[g];
               end
               stop_ok = 1'b1;
               for (int unsigned s = 0; s < SB; s++) begin
                  skip(BIT, ab);
                  if (td[g] !== 1'b1) stop_ok = 1'b0;
               end
               if (!ab) begin
                  if (exp_q[g].size() == 0) begin
                     check($sformatf("frame_expected[%0d]", g), exp_q[g].size(), 1);
                  end else begin
                     want     = exp_q[g].pop_front();
                     want_par = (($countones(want) % 2) == 1) ^ (PODD != 0);
                     check($sformatf("start_bit[%0d]", g), st, 1'b0);
                     check($sformatf("data_byte[%0d]", g), got, want);
                     if (PEN != 0) check($sformatf("parity_bit[%0d]", g), par, want_par);
                     check($sformatf("stop_bits[%0d]", g), stop_ok, 1'b1);
                  end
               end
            end
         end
      end
   end

   // Called on a negedge; returns on the negedge after the accepting edge, TX_Valid still high.
   task automatic send(input int k, input logic [7:0] b, output int unsigned acc);
      tx_data[k]  = b;
      tx_valid[k] = 1'b1;
      acc = 0;
      for (int unsigned c = 0; c < 1000; c++) begin
         if (ready[k] === 1'b1) begin
            @(posedge Clk);
            exp_q[k].push_back(b);
            @(negedge Clk);
            acc = cyc;
            return;
         end
         @(negedge Clk);
      end
      check($sformatf("send_accepted[%0d]", k), ready[k], 1'b1);
   endtask

   task automatic measure(input int k, output int busy_n, output int rdy_low,
                          output logic td0, output logic td1);
      busy_n  = 0;
      rdy_low = 0;
      td0     = td[k];
      td1     = 1'bx;
      for (int unsigned c = 0; c < 400; c++) begin
         if (busy[k] !== 1'b1) break;
         if (c == 1) td1 = td[k];
         busy_n++;
         if (ready[k] !== 1'b1) rdy_low++;
         @(negedge Clk);
      end
   endtask

   task automatic wait_drain(input int k);
      for (int unsigned c = 0; c < 3000; c++) begin
         if (exp_q[k].size() == 0 && busy[k] === 1'b0) break;
         @(negedge Clk);
      end
      check($sformatf("drained[%0d]", k), exp_q[k].size(), 0);
   endtask

   task automatic check_gaps(input int k, input int unsigned n, input int unsigned gap);
      if (start_q[k].size() != n) begin
         check($sformatf("frame_starts[%0d]", k), start_q[k].size(), n);
      end else begin
         for (int unsigned i = 1; i < n; i++)
            check($sformatf("start_gap[%0d].%0d", k, i), start_q[k][i] - start_q[k][i-1], gap);
      end
   endtask

   initial begin : main
      int unsigned a1, a2, a3, gap;
      int          bn, rl, low_n;
      logic        t0, t1;

      tx_valid = '0;
      for (int k = 0; k < NUM; k++) tx_data[k] = '0;
      repeat (3) @(negedge Clk);
      for (int k = 0; k < NUM; k++) begin
         check($sformatf("rst_td[%0d]", k), td[k], 1'b1);
         check($sformatf("rst_ready[%0d]", k), ready[k], 1'b0);
         check($sformatf("rst_busy[%0d]", k), busy[k], 1'b0);
      end
      Rst = 1'b0;
      @(negedge Clk);
      for (int k = 0; k < NUM; k++) check($sformatf("ready_after_rst[%0d]", k), ready[k], 1'b1);

      // Single 8N1 frame: latency, busy length, ready stays high
      send(0, 8'hA5, a1);
      tx_valid[0] = 1'b0;
      measure(0, bn, rl, t0, t1);
      check("td_at_accept", t0, 1'b1);
      check("td_start_latency", t1, 1'b0);
      check("busy_cycles_8n1", bn, 100);
      check("ready_drops_8n1", rl, 0);
      wait_drain(0);

      // Back-to-back pair
      start_q[0].delete();
      send(0, 8'h00, a1);
      send(0, 8'hFF, a2);
      tx_valid[0] = 1'b0;
      wait_drain(0);
      check_gaps(0, 2, 100);

      // Valid held through three bytes
      start_q[0].delete();
      send(0, 8'h11, a1);
      send(0, 8'h22, a2);
      send(0, 8'h33, a3);
      tx_valid[0] = 1'b0;
      check("accept2_offset", a2 - a1, 1);
      check("accept3_offset", a3 - a1, 101);
      wait_drain(0);
      check_gaps(0, 3, 100);

      // Parity variants: even then odd, both 110-cycle frames
      send(1, 8'h07, a1);
      tx_valid[1] = 1'b0;
      measure(1, bn, rl, t0, t1);
      check("busy_cycles_8e1", bn, 110);
      wait_drain(1);
      send(2, 8'h07, a1);
      tx_valid[2] = 1'b0;
      measure(2, bn, rl, t0, t1);
      check("busy_cycles_8o1", bn, 110);
      wait_drain(2);

      // Two stop bits
      start_q[3].delete();
      send(3, 8'h3C, a1);
      send(3, 8'hC3, a2);
      tx_valid[3] = 1'b0;
      wait_drain(3);
      check_gaps(3, 2, 110);

      // Reset at cycle 45 of a frame with a byte held
      send(0, 8'h00, a1);
      send(0, 8'hE7, a2);
      tx_valid[0] = 1'b0;
      repeat (43) @(negedge Clk);
      check("td_mid_frame", td[0], 1'b0);
      check("busy_mid_frame", busy[0], 1'b1);
      Rst = 1'b1;
      @(negedge Clk);
      exp_q[0].delete();
      check("td_after_mid_rst", td[0], 1'b1);
      check("ready_in_mid_rst", ready[0], 1'b0);
      check("busy_in_mid_rst", busy[0], 1'b0);
      @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      check("ready_after_mid_rst", ready[0], 1'b1);
      low_n = 0;
      repeat (200) begin
         if (td[0] !== 1'b1) low_n++;
         @(negedge Clk);
      end
      check("td_low_after_mid_rst", low_n, 0);
      check("busy_after_mid_rst", busy[0], 1'b0);

      // Randomized traffic with mixed gaps on every variant
      for (int k = 0; k < NUM; k++) begin
         for (int unsigned n = 0; n < 8; n++) begin
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) gap = $urandom_range(50, 150);
            if (gap != 0) begin
               tx_valid[k] = 1'b0;
               repeat (gap) @(negedge Clk);
            end
            send(k, 8'($urandom), a1);
         end
         tx_valid[k] = 1'b0;
         wait_drain(k);
      end

      repeat (5) @(negedge Clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: time limit reached, %0d/%0d passed so far", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule
